csr_regfile: RTL and testbench

- Machine-mode control/status register file for the single-issue RISC-V core.
- Sits beside the decode stage, which:
  - reads a CSR combinationally for CSRRW/CSRRS/CSRRC and friends;
  - drives a general write port;
  - drives dedicated trap ports that update mepc/mcause/mtval and mstatus when it detects an exception.
- Holds mstatus, misa, mie, mtvec, mscratch, mepc, mcause, mtval, mip and the ID CSRs.

---
 rtl/csr_regfile.sv | 163 ++++++++++++++++
 tb/tb_csr_regfile.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: combinational read port, general write port and trap update ports.
// Optional 64-bit mcycle/cycle counter is built only when CSR_MCYCLE_EN is defined.
module csr_regfile #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_i,
  input  logic [11:0]     waddr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic            we_mtval_i,
  input  logic [XLEN-1:0] wdata_mtval_i,
  input  logic            we_mepc_i,
  input  logic [XLEN-1:0] wdata_mepc_i,
  input  logic            we_mcause_i,
  input  logic [XLEN-1:0] wdata_mcause_i,
  input  logic            exception_mie_req_i,
  input  logic [11:0]     raddr_i,
  output logic [XLEN-1:0] rdata_o
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;

  localparam logic [1:0]      MXL        = (XLEN == 32) ? 2'd1 : 2'd2;
  localparam logic [XLEN-1:0] MEPC_MASK  = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b01};

  logic            st_mie, st_mpie;
  logic [2:0]      mie_q;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;

  logic [XLEN-1:0] misa_val, mstatus_val, mie_val;

  // misa: MXL in the top two bits, I (bit 8) and M (bit 12) extensions
  assign misa_val = {MXL, {(XLEN-15){1'b0}}, 1'b1, 3'b000, 1'b1, 8'h00};

  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = st_mpie;
    mstatus_val[3]     = st_mie;
    mie_val            = '0;
    mie_val[11]        = mie_q[2];
    mie_val[7]         = mie_q[1];
    mie_val[3]         = mie_q[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_mie     <= 1'b0;
      st_mpie    <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      // trap entry has priority over software writes of mstatus
      if (exception_mie_req_i) begin
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (we_i && waddr_i == A_MSTATUS) begin
        st_mie  <= wdata_i[3];
        st_mpie <= wdata_i[7];
      end

      if (we_i && waddr_i == A_MIE)
        mie_q <= {wdata_i[11], wdata_i[7], wdata_i[3]};
      if (we_i && waddr_i == A_MTVEC)
        mtvec_q <= wdata_i & MTVEC_MASK;
      if (we_i && waddr_i == A_MSCRATCH)
        mscratch_q <= wdata_i;

      if (we_mepc_i)
        mepc_q <= wdata_mepc_i & MEPC_MASK;
      else if (we_i && waddr_i == A_MEPC)
        mepc_q <= wdata_i & MEPC_MASK;

      if (we_mcause_i)
        mcause_q <= wdata_mcause_i;
      else if (we_i && waddr_i == A_MCAUSE)
        mcause_q <= wdata_i;

      if (we_mtval_i)
        mtval_q <= wdata_mtval_i;
      else if (we_i && waddr_i == A_MTVAL)
        mtval_q <= wdata_i;
    end
  end

`ifdef CSR_MCYCLE_EN
  logic [63:0]     mcycle_q, mcycle_nxt;
  logic [XLEN-1:0] cyc_rdata;

  generate
    if (XLEN == 32) begin : g_cyc32
      always_comb begin
        mcycle_nxt = mcycle_q + 64'd1;
        if (we_i && waddr_i == 12'hB00)
          mcycle_nxt = {mcycle_q[63:32], wdata_i};
        else if (we_i && waddr_i == 12'hB80)
          mcycle_nxt = {wdata_i, mcycle_q[31:0]};
      end
      always_comb begin
        cyc_rdata = '0;
        case (raddr_i)
          12'hB00, 12'hC00: cyc_rdata = mcycle_q[31:0];
          12'hB80, 12'hC80: cyc_rdata = mcycle_q[63:32];
          default:          cyc_rdata = '0;
        endcase
      end
    end else begin : g_cyc64
      always_comb begin
        mcycle_nxt = mcycle_q + 64'd1;
        if (we_i && waddr_i == 12'hB00)
          mcycle_nxt = wdata_i;
      end
      always_comb begin
        cyc_rdata = '0;
        case (raddr_i)
          12'hB00, 12'hC00: cyc_rdata = mcycle_q;
          default:          cyc_rdata = '0;
        endcase
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mcycle_q <= '0;
    else      mcycle_q <= mcycle_nxt;
  end
`endif

  always_comb begin
    rdata_o = '0;
    case (raddr_i)
      A_MSTATUS:  rdata_o = mstatus_val;
      A_MISA:     rdata_o = misa_val;
      A_MIE:      rdata_o = mie_val;
      A_MTVEC:    rdata_o = mtvec_q;
      A_MSCRATCH: rdata_o = mscratch_q;
      A_MEPC:     rdata_o = mepc_q;
      A_MCAUSE:   rdata_o = mcause_q;
      A_MTVAL:    rdata_o = mtval_q;
      default: begin
`ifdef CSR_MCYCLE_EN
        rdata_o = cyc_rdata;
`else
        rdata_o = '0;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Self-checking bench for csr_regfile (XLEN=64): vector table plus hand-written reset,
// collision and counter sequences; expected values flow through a scoreboard queue.
module tb_csr_regfile;
  localparam int XLEN = 64;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MISA = 64'h8000_0000_0000_1100;

  logic            clk = 1'b0;
  logic            rst;
  logic            we_i;
  logic [11:0]     waddr_i;
  logic [XLEN-1:0] wdata_i;
  logic            we_mtval_i;
  logic [XLEN-1:0] wdata_mtval_i;
  logic            we_mepc_i;
  logic [XLEN-1:0] wdata_mepc_i;
  logic            we_mcause_i;
  logic [XLEN-1:0] wdata_mcause_i;
  logic            exception_mie_req_i;
  logic [11:0]     raddr_i;
  logic [XLEN-1:0] rdata_o;

  always #5 clk = ~clk;

  csr_regfile #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .we_mtval_i(we_mtval_i), .wdata_mtval_i(wdata_mtval_i),
    .we_mepc_i(we_mepc_i), .wdata_mepc_i(wdata_mepc_i),
    .we_mcause_i(we_mcause_i), .wdata_mcause_i(wdata_mcause_i),
    .exception_mie_req_i(exception_mie_req_i),
    .raddr_i(raddr_i), .rdata_o(rdata_o)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [11:0] waddr;
    logic [63:0] wdata;
    logic        exc;
    logic        we_mepc;
    logic [63:0] mepc;
    logic        we_mcause;
    logic [63:0] mcause;
    logic        we_mtval;
    logic [63:0] mtval;
    logic [11:0] raddr;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] sb_q[$];
  int          tests = 0;
  int          fails = 0;

  function automatic void add_trap(string n, logic [11:0] ra, logic [63:0] ex,
                                   logic w, logic [11:0] wa, logic [63:0] wd, logic exc,
                                   logic wep, logic [63:0] ep, logic wec, logic [63:0] ec,
                                   logic wev, logic [63:0] ev);
    vec_t t;
    t.name = n; t.raddr = ra; t.exp = ex;
    t.we = w; t.waddr = wa; t.wdata = wd; t.exc = exc;
    t.we_mepc = wep; t.mepc = ep; t.we_mcause = wec; t.mcause = ec;
    t.we_mtval = wev; t.mtval = ev;
    vecs.push_back(t);
  endfunction

  function automatic void add(string n, logic [11:0] ra, logic [63:0] ex,
                              logic w = 1'b0, logic [11:0] wa = 12'h0, logic [63:0] wd = 64'h0);
    add_trap(n, ra, ex, w, wa, wd, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
  endfunction

  task automatic idle();
    we_i = 1'b0; waddr_i = 12'h0; wdata_i = '0;
    we_mtval_i = 1'b0; wdata_mtval_i = '0;
    we_mepc_i = 1'b0; wdata_mepc_i = '0;
    we_mcause_i = 1'b0; wdata_mcause_i = '0;
    exception_mie_req_i = 1'b0;
  endtask

  task automatic drive(input vec_t t);
    we_i = t.we; waddr_i = t.waddr; wdata_i = t.wdata;
    exception_mie_req_i = t.exc;
    we_mepc_i = t.we_mepc; wdata_mepc_i = t.mepc;
    we_mcause_i = t.we_mcause; wdata_mcause_i = t.mcause;
    we_mtval_i = t.we_mtval; wdata_mtval_i = t.mtval;
    raddr_i = t.raddr;
  endtask

  task automatic check(input string n, input logic [63:0] got);
    logic [63:0] e;
    tests++;
    if (sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s: no expected value queued, got %h", n, got);
    end else begin
      e = sb_q.pop_front();
      if (got !== e) begin
        fails++;
        $display("FAIL %s: got %h expected %h", n, got, e);
      end
    end
  endtask

  task automatic expect_now(input string n, input logic [63:0] e);
    sb_q.push_back(e);
    check(n, rdata_o);
  endtask

  initial begin
    add("rst_mstatus", 12'h300, 64'h1800);
    add("rst_misa",    12'h301, MISA);
    add("rst_mepc",    12'h341, 64'h0);
    add("rst_mtvec",   12'h305, 64'h0);
    add("rst_mie",     12'h304, 64'h0);
    add("rst_mcause",  12'h342, 64'h0);
    add("wr_same_cycle", 12'h340, 64'h0, 1'b1, 12'h340, 64'hDEADBEEF);
    add("wr_next_cycle", 12'h340, 64'hDEADBEEF);
    add("mstatus_wr",    12'h300, 64'h1800, 1'b1, 12'h300, ONES);
    add("mstatus_mask",  12'h300, 64'h1888);
    add("mie_wr",        12'h304, 64'h0, 1'b1, 12'h304, ONES);
    add("mie_mask",      12'h304, 64'h888);
    add("mepc_wr",       12'h341, 64'h0, 1'b1, 12'h341, 64'h1003);
    add("mepc_mask",     12'h341, 64'h1000);
    add("misa_wr",       12'h301, MISA, 1'b1, 12'h301, 64'h0);
    add("misa_ro",       12'h301, MISA);
    add("mtvec_wr",      12'h305, 64'h0, 1'b1, 12'h305, ONES);
    add("mtvec_mask",    12'h305, 64'hFFFF_FFFF_FFFF_FFFD);
    add("mip_wr",        12'h344, 64'h0, 1'b1, 12'h344, ONES);
    add("mip_zero",      12'h344, 64'h0);
    add("mhartid_wr",    12'hF14, 64'h0, 1'b1, 12'hF14, ONES);
    add("mhartid_zero",  12'hF14, 64'h0);
    add("unimpl_wr",     12'h123, 64'h0, 1'b1, 12'h123, ONES);
    add("mscratch_kept", 12'h340, 64'hDEADBEEF);
    add("mstatus_mie_wr", 12'h300, 64'h1888, 1'b1, 12'h300, 64'h8);
    add("mstatus_mie",    12'h300, 64'h1808);
    add_trap("trap_entry", 12'h300, 64'h1808, 1'b0, 12'h0, 64'h0, 1'b1,
             1'b1, 64'h8000_0010, 1'b1, 64'h2, 1'b1, 64'h13);
    add("trap_mstatus", 12'h300, 64'h1880);
    add("trap_mepc",    12'h341, 64'h8000_0010);
    add("trap_mcause",  12'h342, 64'h2);
    add("trap_mtval",   12'h343, 64'h13);
    add_trap("coll_mepc_wr", 12'h341, 64'h8000_0010, 1'b1, 12'h341, 64'h111, 1'b0,
             1'b1, 64'h200, 1'b0, 64'h0, 1'b0, 64'h0);
    add("coll_mepc", 12'h341, 64'h200);
    add_trap("coll_exc_wr", 12'h300, 64'h1880, 1'b1, 12'h300, 64'h8, 1'b1,
             1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    add("coll_exc", 12'h300, 64'h1800);
    add_trap("coll_mcause_wr", 12'h342, 64'h2, 1'b1, 12'h342, 64'h5, 1'b0,
             1'b0, 64'h0, 1'b1, 64'h7, 1'b0, 64'h0);
    add("coll_mcause", 12'h342, 64'h7);
    add_trap("multi_wr", 12'h343, 64'h13, 1'b1, 12'h340, 64'h55, 1'b0,
             1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h66);
    add("multi_mscratch", 12'h340, 64'h55);
    add("multi_mtval",    12'h343, 64'h66);
    add_trap("trap_mepc_lsb_wr", 12'h341, 64'h200, 1'b0, 12'h0, 64'h0, 1'b0,
             1'b1, 64'h123, 1'b0, 64'h0, 1'b0, 64'h0);
    add("trap_mepc_lsb", 12'h341, 64'h120);

    idle();
    raddr_i = 12'h300;
    rst = 1'b0;
    #1;
    expect_now("por_mstatus", 64'h1800);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      sb_q.push_back(vecs[i].exp);
      #2;
      check(vecs[i].name, rdata_o);
    end

    // asynchronous reset in mid-cycle with writes pending
    @(negedge clk);
    idle();
    we_i = 1'b1; waddr_i = 12'h300; wdata_i = 64'h88; raddr_i = 12'h300;
    @(negedge clk);
    idle();
    #2;
    expect_now("pre_reset_mstatus", 64'h1888);
    we_i = 1'b1; waddr_i = 12'h340; wdata_i = 64'h77;
    #1;
    rst = 1'b0;
    #1;
    expect_now("async_rst_mstatus", 64'h1800);
    raddr_i = 12'h340;
    #1;
    expect_now("async_rst_mscratch", 64'h0);
    @(posedge clk);
    #2;
    expect_now("rst_blocks_write", 64'h0);
    raddr_i = 12'h343;
    #1;
    expect_now("async_rst_mtval", 64'h0);
    @(negedge clk);
    idle();
    rst = 1'b1;

`ifdef CSR_MCYCLE_EN
    @(negedge clk);
    idle();
    we_i = 1'b1; waddr_i = 12'hB00; wdata_i = 64'h5; raddr_i = 12'hB00;
    @(negedge clk);
    idle();
    raddr_i = 12'hB00;
    #2;
    expect_now("mcycle_wr", 64'h5);
    @(negedge clk);
    we_i = 1'b1; waddr_i = 12'hC00; wdata_i = 64'h100; raddr_i = 12'hC00;
    #2;
    expect_now("cycle_alias", 64'h6);
    @(negedge clk);
    idle();
    raddr_i = 12'hB00;
    #2;
    expect_now("cycle_ro", 64'h7);
    @(negedge clk);
    #2;
    expect_now("mcycle_inc", 64'h8);
`else
    @(negedge clk);
    idle();
    we_i = 1'b1; waddr_i = 12'hB00; wdata_i = 64'h5; raddr_i = 12'hB00;
    #2;
    expect_now("mcycle_absent", 64'h0);
    @(negedge clk);
    idle();
    raddr_i = 12'hB00;
    #2;
    expect_now("mcycle_absent_wr", 64'h0);
    raddr_i = 12'hC00;
    #1;
    expect_now("cycle_absent", 64'h0);
`endif

    @(negedge clk);
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
